// File: rtl/time_entry_encoder_pkg.sv
// Shared constants and types for the keyed time-entry encoder.
// Key codes match the display path digit space.
package time_entry_encoder_pkg;

   localparam logic [3:0] KEY_DIG_MAX = 4'd9;
   localparam logic [3:0] KEY_A       = 4'd12;
   localparam logic [3:0] KEY_P       = 4'd13;
   localparam logic [3:0] KEY_BLANK   = 4'd14;
   localparam logic [3:0] KEY_OFF     = 4'd15;

   localparam logic [6:0] NO_TIME   = 7'h7F;
   localparam logic [6:0] HH_MAX_24 = 7'd23;
   localparam logic [6:0] HH_MAX_12 = 7'd12;
   localparam logic [6:0] MS_MAX    = 7'd59;

   localparam logic [2:0] CUR_H1   = 3'd0;
   localparam logic [2:0] CUR_H2   = 3'd1;
   localparam logic [2:0] CUR_M1   = 3'd2;
   localparam logic [2:0] CUR_M2   = 3'd3;
   localparam logic [2:0] CUR_S1AP = 3'd4;
   localparam logic [2:0] CUR_S2   = 3'd5;
   localparam logic [2:0] CUR_IDLE = 3'd7;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_H1,
      ST_H2,
      ST_M1,
      ST_M2,
      ST_S1,
      ST_S2,
      ST_AP,
      ST_CHECK
   } state_t;

endpackage

// File: rtl/time_entry_encoder_bcd2_to_bin.sv
// Two BCD digits to a 7-bit binary value, tens*10 + ones via shifts.
module bcd2_to_bin (
   input  logic [3:0] i_tens,
   input  logic [3:0] i_ones,
   output logic [6:0] o_bin
);

   logic [6:0] w_tens;

   assign w_tens = {3'b000, i_tens};
   assign o_bin  = (w_tens << 3) + (w_tens << 1) + {3'b000, i_ones};

endmodule

// File: rtl/time_entry_encoder.sv
// Assembles keyed digits into validated 24-hour HH/MM/SS with a valid pulse.
// Optional entry timeout enabled by defining TIME_ENTRY_TIMEOUT_EN.
module time_entry_encoder
   import time_entry_encoder_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       clear,
   input  logic       showAP,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic [6:0] finalHH,
   output logic [6:0] finalMM,
   output logic [6:0] finalSS,
   output logic       time_valid,
   output logic       entry_error,
   output logic       busy,
   output logic [2:0] cursor
);

   state_t     r_state;
   state_t     w_state_next;
   logic       r_mode_ap, r_pm;
   logic [3:0] r_h1, r_h2, r_m1, r_m2, r_s1, r_s2;
   logic [6:0] r_final_hh, r_final_mm, r_final_ss;
   logic       r_time_valid, r_entry_error;

   logic       w_key_digit, w_key_ap, w_accept, w_clear_busy, w_timeout;
   logic       w_pulse_valid, w_pulse_error, w_entry_ok;
   logic [6:0] w_hh, w_mm, w_ss, w_hh_final;

   bcd2_to_bin u_hh (.i_tens(r_h1), .i_ones(r_h2), .o_bin(w_hh));
   bcd2_to_bin u_mm (.i_tens(r_m1), .i_ones(r_m2), .o_bin(w_mm));
   bcd2_to_bin u_ss (.i_tens(r_s1), .i_ones(r_s2), .o_bin(w_ss));

   assign w_key_digit  = key_valid && (key_code <= KEY_DIG_MAX);
   assign w_key_ap     = key_valid && ((key_code == KEY_A) || (key_code == KEY_P));
   assign w_clear_busy = clear && (r_state != ST_IDLE);
   assign w_accept     = !w_clear_busy &&
                         (((r_state != ST_IDLE) && (r_state != ST_AP) &&
                           (r_state != ST_CHECK) && w_key_digit) ||
                          ((r_state == ST_AP) && w_key_ap));

   always_comb begin
      if (r_mode_ap) begin
         w_entry_ok = (w_hh != 7'd0) && (w_hh <= HH_MAX_12) && (w_mm <= MS_MAX);
      end else begin
         w_entry_ok = (w_hh <= HH_MAX_24) && (w_mm <= MS_MAX) && (w_ss <= MS_MAX);
      end
   end

   // 12A is midnight and 12P is noon; other PM hours shift by twelve.
   always_comb begin
      w_hh_final = w_hh;
      if (r_mode_ap) begin
         if (w_hh == HH_MAX_12) begin
            w_hh_final = r_pm ? HH_MAX_12 : 7'd0;
         end else if (r_pm) begin
            w_hh_final = w_hh + 7'd12;
         end
      end
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_state_next  = r_state;
      w_pulse_valid = 1'b0;
      w_pulse_error = 1'b0;
      unique case (r_state)
         ST_IDLE:  if (start && !clear) w_state_next = ST_H1;
         ST_H1:    if (w_key_digit) w_state_next = ST_H2;
         ST_H2:    if (w_key_digit) w_state_next = ST_M1;
         ST_M1:    if (w_key_digit) w_state_next = ST_M2;
         ST_M2:    if (w_key_digit) w_state_next = r_mode_ap ? ST_AP : ST_S1;
         ST_S1:    if (w_key_digit) w_state_next = ST_S2;
         ST_S2:    if (w_key_digit) w_state_next = ST_CHECK;
         ST_AP:    if (w_key_ap) w_state_next = ST_CHECK;
         ST_CHECK: begin
            w_state_next  = w_entry_ok ? ST_IDLE : ST_H1;
            w_pulse_valid = w_entry_ok;
            w_pulse_error = !w_entry_ok;
         end
         default:  w_state_next = ST_IDLE;
      endcase
      if (w_clear_busy) begin
         w_state_next  = ST_H1;
         w_pulse_valid = 1'b0;
         w_pulse_error = 1'b0;
      end else if (w_timeout) begin
         w_state_next  = ST_IDLE;
         w_pulse_valid = 1'b0;
         w_pulse_error = 1'b1;
      end
   end

   // NOTE: state is updated with non-blocking assignments; reset is synchronous.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_mode_ap     <= 1'b0;
         r_pm          <= 1'b0;
         r_h1          <= 4'd0;
         r_h2          <= 4'd0;
         r_m1          <= 4'd0;
         r_m2          <= 4'd0;
         r_s1          <= 4'd0;
         r_s2          <= 4'd0;
         r_final_hh    <= NO_TIME;
         r_final_mm    <= 7'd0;
         r_final_ss    <= 7'd0;
         r_time_valid  <= 1'b0;
         r_entry_error <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_time_valid  <= w_pulse_valid;
         r_entry_error <= w_pulse_error;
         if ((r_state == ST_IDLE) && start && !clear) r_mode_ap <= showAP;
         if (w_clear_busy) begin
            r_h1 <= 4'd0;
            r_h2 <= 4'd0;
            r_m1 <= 4'd0;
            r_m2 <= 4'd0;
            r_s1 <= 4'd0;
            r_s2 <= 4'd0;
         end else if (w_accept) begin
            case (r_state)
               ST_H1:   r_h1 <= key_code;
               ST_H2:   r_h2 <= key_code;
               ST_M1:   r_m1 <= key_code;
               ST_M2:   r_m2 <= key_code;
               ST_S1:   r_s1 <= key_code;
               ST_S2:   r_s2 <= key_code;
               ST_AP:   r_pm <= (key_code == KEY_P);
               default: ;
            endcase
         end
         if (w_pulse_valid) begin
            r_final_hh <= w_hh_final;
            r_final_mm <= w_mm;
            r_final_ss <= r_mode_ap ? 7'd0 : w_ss;
         end
      end
   end

`ifdef TIME_ENTRY_TIMEOUT_EN
   logic [25:0] r_idle_cnt;

   always_ff @(posedge clk) begin
      if (rst || (r_state == ST_IDLE) || w_accept || clear ||
          ((w_state_next == ST_H1) && (r_state != ST_H1))) begin
         r_idle_cnt <= 26'd0;
      end else begin
         r_idle_cnt <= r_idle_cnt + 26'd1;
      end
   end

   assign w_timeout = (r_state != ST_IDLE) && (r_state != ST_CHECK) && !w_accept &&
                      !w_clear_busy && (r_idle_cnt == 26'(TIMEOUT_CYCLES - 1));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
   assign w_timeout        = 1'b0;
`endif

   always_comb begin
      unique case (r_state)
         ST_H1:        cursor = CUR_H1;
         ST_H2:        cursor = CUR_H2;
         ST_M1:        cursor = CUR_M1;
         ST_M2:        cursor = CUR_M2;
         ST_S1, ST_AP: cursor = CUR_S1AP;
         ST_S2:        cursor = CUR_S2;
         default:      cursor = CUR_IDLE;
      endcase
   end

   assign busy        = (r_state != ST_IDLE);
   assign finalHH     = r_final_hh;
   assign finalMM     = r_final_mm;
   assign finalSS     = r_final_ss;
   assign time_valid  = r_time_valid;
   assign entry_error = r_entry_error;

endmodule

// File: doc/time_entry_encoder.md
Name: time_entry_encoder

Overview:
- Inverse of the time-to-digit display path: accepts keyed digit codes one per strobe and assembles them into binary hour/minute/second values.
- Validates the entry, converts 12-hour entries to 24-hour form, and publishes finalHH/finalMM/finalSS with a one-cycle valid pulse.
- Sits between the button/keypad debouncer and the timekeeping core's load port.
- Uses the same digit code space as the display path: 0-9 digits, 12 'A', 13 'P', 14 blank, 15 off.

Parameters:
- TIMEOUT_CYCLES, 50_000_000, idle cycles before an unfinished entry aborts (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: begin a new entry
- clear  in  1  pulse: restart the current entry at the first digit
- showAP  in  1  sampled at start; 1 = 12-hour entry (HH MM A/P), 0 = 24-hour entry (HH MM SS)
- key_valid  in  1  one-cycle strobe qualifying key_code
- key_code  in  4  digit 0-9, 12='A', 13='P'; all other codes are ignored
- finalHH  out  7  binary hours 0-23; 7'b1111111 = no time set
- finalMM  out  7  binary minutes 0-59
- finalSS  out  7  binary seconds 0-59
- time_valid  out  1  one-cycle pulse when final* update
- entry_error  out  1  one-cycle pulse on rejected entry or timeout
- busy  out  1  high in any state except IDLE
- cursor  out  3  current position for display blink: 0=H1, 1=H2, 2=M1, 3=M2, 4=S1/AP, 5=S2, 7=idle

Behaviour:
- Reset: state IDLE; finalHH=7'h7F; finalMM=0; finalSS=0; time_valid=0; entry_error=0; busy=0; cursor=7; digit registers 0.
- States: IDLE -> H1 -> H2 -> M1 -> M2 -> (24h: S1 -> S2 | 12h: AP) -> CHECK -> IDLE.
- IDLE:
  - start moves to H1 and latches showAP into mode_ap.
  - key_valid and clear are ignored.
- Digit states (H1..S2):
  - Advance only on key_valid with key_code <= 9; the digit is stored.
  - Codes 10-15 are ignored and the state holds.
- AP state:
  - Advances on key_valid with code 12 or 13, storing pm = (code==13).
  - Digits and other codes are ignored.
- clear:
  - In any busy state, returns to H1 and zeroes the digit registers.
  - Outputs are unchanged; no pulse.
  - clear beats a simultaneous key_valid.
- start while busy: ignored.
- start and clear in the same cycle from IDLE: clear wins; stay IDLE.
- CHECK (exactly one cycle):
  - hh = h1*10+h2, mm = m1*10+m2, ss = s1*10+s2, computed as (x<<3)+(x<<1)+y in 7 bits; no overflow, since max is 99.
  - 24h valid iff hh<=23, mm<=59, ss<=59.
  - 12h valid iff 1<=hh<=12 and mm<=59; ss is forced to 0.
  - 12h conversion: 12A->0, 12P->12, hA->h, hP->h+12.
  - Valid: at the CHECK clock edge, register final*, assert time_valid for the next cycle, go to IDLE.
  - Invalid: final* unchanged, assert entry_error for the next cycle, go to H1 (still busy) for re-entry.
- Latency: the last accepted key at edge k; CHECK during cycle k..k+1; time_valid/entry_error high during k+1..k+2.
- Pulses are never asserted together and never last more than one cycle.
- Reset mid-entry: immediate return to reset values; the partial entry is discarded.

Optional Feature:
- Macro: TIME_ENTRY_TIMEOUT_EN.
- With the macro:
  - A 26-bit idle counter runs while busy, cleared on any accepted key, clear, or state entry to H1.
  - On reaching TIMEOUT_CYCLES-1: go to IDLE, pulse entry_error, outputs unchanged.
- Without the macro: no counter; the block waits in a digit state indefinitely.

Decomposition:
- Shared package:
  - Key-code constants: KEY_A=12, KEY_P=13, KEY_BLANK=14, KEY_OFF=15.
  - NO_TIME=7'h7F.
  - Limits: HH_MAX_24=23, HH_MAX_12=12, MS_MAX=59.
  - State enum typedef.
  - Cursor position constants.
- One sub-module: bcd2_to_bin (two 4-bit digits in, 7-bit binary out, combinational), instantiated three times.

Test Plan:
- 24h entry: start(showAP=0), keys 1,3,4,5,0,9 -> time_valid one cycle after CHECK; finalHH=13, finalMM=45, finalSS=9; busy=0.
- 12h entry: start(showAP=1), keys 1,2,0,5,A -> finalHH=0, finalMM=5, finalSS=0; then keys 0,7,3,0,P -> finalHH=19, finalMM=30.
- Invalid entry: 24h keys 2,4,0,0,0,0 -> entry_error pulse, final* unchanged, cursor=0, busy=1. 12h keys 0,0,1,0,A -> entry_error.
- Ignored and clear keys: codes 11 and 14 mid-entry hold the cursor. clear after 3 digits -> cursor=0; then 0,8,1,5,3,0 -> finalHH=8, finalMM=15, finalSS=30.
- Reset mid-entry after 2 digits -> finalHH=7'h7F, cursor=7, no pulses. start+clear in the same cycle from IDLE -> stays IDLE.
- With TIME_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=16: start, one key, then 16 idle cycles -> entry_error pulse, busy=0, outputs unchanged.
